// File: rtl/alu_exec_if.sv
// Request/response bundle between the issue stage and alu_exec_unit.
interface alu_exec_if #(
  parameter int WIDTH = 32
);
  logic             iValid;
  logic             oReady;
  logic [3:0]       iALUctrl;
  logic [WIDTH-1:0] iSrcA;
  logic [WIDTH-1:0] iSrcB;
  logic [4:0]       iShamt;
  logic             oValid;
  logic             iReady;
  logic [WIDTH-1:0] oResult;
  logic             oZero;
  logic             oIllegal;

  modport master (
    output iValid, iALUctrl, iSrcA, iSrcB, iShamt, iReady,
    input  oReady, oValid, oResult, oZero, oIllegal
  );

  modport slave (
    input  iValid, iALUctrl, iSrcA, iSrcB, iShamt, iReady,
    output oReady, oValid, oResult, oZero, oIllegal
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Single-issue ALU with registered result and valid/ready handshake.
// Define ALU_FAST_SHIFT_EN for single-cycle barrel shifts; default shifts iterate one bit per cycle.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input logic        clk,
  input logic        rst,
  alu_exec_if.slave  bus
);

  // state  | meaning
  // IDLE   | ready for a request
  // SHIFT  | iterative shift in progress (absent with ALU_FAST_SHIFT_EN)
  // DONE   | result held until consumer takes it
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;
  logic [WIDTH-1:0] alu_res;
  logic             is_shift;

  assign is_shift = (bus.iALUctrl == 4'd7) || (bus.iALUctrl == 4'd8) || (bus.iALUctrl == 4'd9);

`ifdef ALU_FAST_SHIFT_EN
  logic sat;
  assign sat = 32'(bus.iShamt) >= WIDTH;
`else
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [1:0]       kind_q, kind_d;
`endif

  always_comb begin
    alu_res = '0;
    case (bus.iALUctrl)
      4'd0: alu_res = bus.iSrcA + bus.iSrcB;
      4'd1: alu_res = bus.iSrcA - bus.iSrcB;
      4'd2: alu_res = bus.iSrcA & bus.iSrcB;
      4'd3: alu_res = bus.iSrcA | bus.iSrcB;
      4'd4: alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.iSrcA) < $signed(bus.iSrcB))};
      4'd5: alu_res = bus.iSrcA ^ bus.iSrcB;
      4'd6: alu_res = ~(bus.iSrcA | bus.iSrcB);
`ifdef ALU_FAST_SHIFT_EN
      4'd7: alu_res = sat ? '0 : (bus.iSrcB << bus.iShamt);
      4'd8: alu_res = sat ? '0 : (bus.iSrcB >> bus.iShamt);
      4'd9: alu_res = sat ? {WIDTH{bus.iSrcB[WIDTH-1]}}
                          : WIDTH'($signed(bus.iSrcB) >>> bus.iShamt);
`endif
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
`ifndef ALU_FAST_SHIFT_EN
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    kind_d    = kind_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.iValid) begin
`ifndef ALU_FAST_SHIFT_EN
          if (is_shift) begin
            sh_d    = bus.iSrcB;
            cnt_d   = bus.iShamt;
            kind_d  = bus.iALUctrl[1:0];
            state_d = S_SHIFT;
          end else
`endif
          begin
            result_d  = alu_res;
            zero_d    = (alu_res == '0);
            illegal_d = (bus.iALUctrl >= 4'd10) && !is_shift;
            state_d   = S_DONE;
          end
        end
      end
`ifndef ALU_FAST_SHIFT_EN
      S_SHIFT: begin
        if (cnt_q != 5'd0) begin
          cnt_d = cnt_q - 5'd1;
          // kind holds op[1:0]: 7 -> 11 (sll), 9 -> 01 (sra), 8 -> 00 (srl)
          case (kind_q)
            2'b11:   sh_d = {sh_q[WIDTH-2:0], 1'b0};
            2'b01:   sh_d = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
            default: sh_d = {1'b0, sh_q[WIDTH-1:1]};
          endcase
        end else begin
          result_d  = sh_q;
          zero_d    = (sh_q == '0);
          illegal_d = 1'b0;
          state_d   = S_DONE;
        end
      end
`endif
      S_DONE: begin
        if (bus.iReady) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      result_q  <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
      sh_q      <= '0;
      cnt_q     <= '0;
      kind_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
`ifndef ALU_FAST_SHIFT_EN
      sh_q      <= sh_d;
      cnt_q     <= cnt_d;
      kind_q    <= kind_d;
`endif
    end
  end

  assign bus.oReady   = (state_q == S_IDLE);
  assign bus.oValid   = (state_q == S_DONE);
  assign bus.oResult  = result_q;
  assign bus.oZero    = zero_q;
  assign bus.oIllegal = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector and random check of alu_exec_unit against a behavioural model.
module tb_alu_exec_unit;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;

  alu_exec_if #(.WIDTH(32)) bus ();
  alu_exec_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  s;
    logic [31:0] res;
    logic        z;
    logic        il;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [3:0] c, input logic [4:0] s);
`ifdef ALU_FAST_SHIFT_EN
    return 1;
`else
    return (c == 4'd7 || c == 4'd8 || c == 4'd9) ? int'(s) + 2 : 1;
`endif
  endfunction

  function automatic logic [31:0] model(input logic [3:0] c, input logic [31:0] a,
                                        input logic [31:0] b, input logic [4:0] s);
    logic [31:0] r;
    r = b;
    case (c)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd5: return a ^ b;
      4'd6: return ~(a | b);
      4'd7: begin for (int i = 0; i < int'(s); i++) r = {r[30:0], 1'b0}; return r; end
      4'd8: begin for (int i = 0; i < int'(s); i++) r = {1'b0, r[31:1]}; return r; end
      4'd9: begin for (int i = 0; i < int'(s); i++) r = {r[31], r[31:1]}; return r; end
      default: return 32'd0;
    endcase
  endfunction

  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] s, output logic [31:0] r, output logic z,
                        output logic il, output int lat);
    @(negedge clk);
    bus.iALUctrl = c; bus.iSrcA = a; bus.iSrcB = b; bus.iShamt = s; bus.iValid = 1'b1;
    @(posedge clk); #1;
    bus.iValid = 1'b0;
    lat = 1;
    while (!bus.oValid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    r = bus.oResult; z = bus.oZero; il = bus.oIllegal;
  endtask

  task automatic release_op();
    @(negedge clk);
    bus.iReady = 1'b1;
    @(posedge clk); #1;
    bus.iReady = 1'b0;
    chk("release_ready", 32'(bus.oReady), 32'd1);
    chk("release_valid", 32'(bus.oValid), 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    logic        z, il;
    int          lat;
    logic [3:0]  c;
    logic [31:0] a, b;
    logic [4:0]  s;

    vecs[0]  = '{4'd1,  32'd5,        32'd7,        5'd0,  32'hFFFF_FFFE, 1'b0, 1'b0, 1};
    vecs[1]  = '{4'd4,  32'hFFFF_FFFF, 32'd1,       5'd0,  32'd1,         1'b0, 1'b0, 1};
    vecs[2]  = '{4'd6,  32'd0,        32'd0,        5'd0,  32'hFFFF_FFFF, 1'b0, 1'b0, 1};
    vecs[3]  = '{4'd0,  32'hFFFF_FFFF, 32'd1,       5'd0,  32'd0,         1'b1, 1'b0, 1};
    vecs[4]  = '{4'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hF000_F000, 1'b0, 1'b0, 1};
    vecs[5]  = '{4'd3,  32'hF0F0_F0F0, 32'h0F0F_0F0F, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1};
    vecs[6]  = '{4'd5,  32'hAAAA_AAAA, 32'hFFFF_FFFF, 5'd0, 32'h5555_5555, 1'b0, 1'b0, 1};
    vecs[7]  = '{4'd4,  32'd1,        32'hFFFF_FFFF, 5'd0,  32'd0,         1'b1, 1'b0, 1};
    vecs[8]  = '{4'd12, 32'd3,        32'd3,        5'd0,  32'd0,         1'b1, 1'b1, 1};
    vecs[9]  = '{4'd9,  32'd0,        32'h8000_0000, 5'd4,  32'hF800_0000, 1'b0, 1'b0, 6};
    vecs[10] = '{4'd9,  32'd0,        32'h8000_0000, 5'd0,  32'h8000_0000, 1'b0, 1'b0, 2};
    vecs[11] = '{4'd7,  32'd0,        32'd1,        5'd31, 32'h8000_0000, 1'b0, 1'b0, 33};
    vecs[12] = '{4'd8,  32'd0,        32'h8000_0000, 5'd31, 32'd1,         1'b0, 1'b0, 33};
    vecs[13] = '{4'd15, 32'd5,        32'd0,        5'd0,  32'd0,         1'b1, 1'b1, 1};
    vecs[14] = '{4'd7,  32'd0,        32'd0,        5'd3,  32'd0,         1'b1, 1'b0, 5};

    bus.iValid = 1'b0; bus.iReady = 1'b0; bus.iALUctrl = '0;
    bus.iSrcA = '0; bus.iSrcB = '0; bus.iShamt = '0;
    rst = 1'b1;
    #1;
    chk("rst_valid",   32'(bus.oValid),   32'd0);
    chk("rst_ready",   32'(bus.oReady),   32'd1);
    chk("rst_result",  bus.oResult,       32'd0);
    chk("rst_zero",    32'(bus.oZero),    32'd1);
    chk("rst_illegal", 32'(bus.oIllegal), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].c, vecs[i].a, vecs[i].b, vecs[i].s, r, z, il, lat);
      chk($sformatf("vec%0d_valid", i),   32'(bus.oValid), 32'd1);
      chk($sformatf("vec%0d_ready", i),   32'(bus.oReady), 32'd0);
      chk($sformatf("vec%0d_result", i),  r, vecs[i].res);
      chk($sformatf("vec%0d_zero", i),    32'(z), 32'(vecs[i].z));
      chk($sformatf("vec%0d_illegal", i), 32'(il), 32'(vecs[i].il));
`ifdef ALU_FAST_SHIFT_EN
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd1);
`else
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
`endif
      release_op();
    end

    // Backpressure: result held, new requests ignored, release edge accepts nothing.
    run_op(4'd0, 32'd1, 32'd2, 5'd0, r, z, il, lat);
    chk("bp_first", r, 32'd3);
    @(negedge clk);
    bus.iValid = 1'b1; bus.iALUctrl = 4'd5; bus.iSrcA = 32'h1234_5678; bus.iSrcB = 32'd9;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp_result", bus.oResult, 32'd3);
      chk("bp_ready",  32'(bus.oReady), 32'd0);
      chk("bp_valid",  32'(bus.oValid), 32'd1);
    end
    @(negedge clk);
    bus.iReady = 1'b1;
    @(posedge clk); #1;
    chk("bp_rel_valid",  32'(bus.oValid), 32'd0);
    chk("bp_rel_ready",  32'(bus.oReady), 32'd1);
    chk("bp_rel_result", bus.oResult, 32'd3);
    @(negedge clk);
    bus.iValid = 1'b0; bus.iReady = 1'b0;

    // Reset during a long operation aborts it at once.
    @(negedge clk);
    bus.iALUctrl = 4'd8; bus.iSrcB = 32'hFFFF_FFFF; bus.iShamt = 5'd20; bus.iValid = 1'b1;
    @(posedge clk); #1;
    bus.iValid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_valid",  32'(bus.oValid), 32'd0);
    chk("arst_ready",  32'(bus.oReady), 32'd1);
    chk("arst_result", bus.oResult, 32'd0);
    chk("arst_zero",   32'(bus.oZero), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    run_op(4'd0, 32'd2, 32'd2, 5'd0, r, z, il, lat);
    chk("post_rst_result",  r, 32'd4);
    chk("post_rst_latency", 32'(lat), 32'd1);
    release_op();

    // Random vectors against the model; iReady sometimes held high outside DONE.
    for (int n = 0; n < 300; n++) begin
      c = 4'($urandom_range(0, 15));
      a = $urandom; b = $urandom;
      s = 5'($urandom_range(0, 31));
      bus.iReady = n[0];
      run_op(c, a, b, s, r, z, il, lat);
      chk("rnd_result",  r, model(c, a, b, s));
      chk("rnd_zero",    32'(z), 32'(model(c, a, b, s) == 32'd0));
      chk("rnd_illegal", 32'(il), 32'(c >= 4'd10));
      chk("rnd_latency", 32'(lat), 32'(exp_lat(c, s)));
      if (bus.oValid) release_op();
      else begin
        @(negedge clk); bus.iReady = 1'b0;
        @(posedge clk); #1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
